argmax_stream: RTL
==================

# argmax_stream

Streaming classifier head that sits directly downstream of the fully connected layer. It consumes the layer's output stream of M signed T-bit values per vector and emits one index per vector: the position of the largest value. It uses the same valid/ready handshake as the layer, so it attaches to the layer's output port with no glue logic. It accumulates the next vector while an earlier result is still waiting to be taken.

## Interface
- M, 16, values per vector (layer output count); M ≥ 2
- T, 20, data width in bits, two's complement
- IW, $clog2(M), index width (derived localparam, not overridable)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- input_valid  in  1  upstream has a value on input_data
- input_ready  out  1  block accepts input_data this cycle
- input_data  in  T  signed value, element order 0..M-1 within a vector
- output_valid  out  1  output_data holds a result
- output_ready  in  1  downstream takes output_data this cycle
- output_data  out  IW  argmax index of the completed vector

## Operation
- An input beat is accepted when input_valid && input_ready at posedge. An output beat is taken when output_valid && output_ready at posedge.
- Element counter cnt runs 0..M-1. It increments on each accepted beat and wraps to 0 after element M-1.
- Running state is best_val (T bits, signed) and best_idx (IW bits).
  - Element 0 loads best_val = data and best_idx = 0 unconditionally.
  - Element k>0 replaces the running state only if data > best_val (signed, strict). Ties therefore keep the lowest index.
- Final element (cnt==M-1):
  - The winner is computed combinationally, including that element.
  - The winner is written to output_data, and output_valid is set.
  - Running state needs no clear, because the next element 0 reloads it.
- input_ready = !(cnt==M-1 && output_valid && !output_ready).
  - Only the final element of a vector stalls, and only while the previous result is unread.
  - Elements 0..M-2 of the next vector flow freely.
- output_valid rules:
  - Clears on a taken output beat unless a new final element is accepted on the same edge.
  - In that same-edge case it stays 1, and output_data takes the new index.
- output_data holds stable while output_valid && !output_ready.
- No arithmetic beyond signed compare. No width growth.

## Timing
- Reset values:
  - output_valid = 0, output_data = 0, cnt = 0, best_val = 0, best_idx = 0.
  - input_ready = 1 from the first cycle after reset.
- Latency: final element accepted at edge n → output_valid = 1 and the index is visible after edge n, in cycle n+1.
- Throughput: one element per cycle sustained when output_ready = 1. The M-cycle vector cadence leaves no bubbles.
- Reset mid-vector discards the partial vector and any pending result. The next accepted beat is element 0.
- input_ready is combinational from cnt, output_valid and output_ready. It has no dependency on input_valid.

## Configuration
- ARGMAX_RELU_EN defined: each input is clamped to 0 if negative before the compare. This fuses the ReLU for a layer built without activation. Result for an all-negative vector is index 0.
- Not defined: raw signed compare.
- Port list and timing are identical either way.

## Structure
- The shared package holds:
  - typedef for the signed T-bit data word
  - an index-width helper function
  - the tie-break rule constant (lowest index wins)
- One natural sub-module is argmax_cmp. It is combinational: optional clamp, signed strict compare, mux of value and index. It is instantiated once for the running update.
- The top module holds the counter, running registers, output register and handshake.

## Test plan
- Ascending vector 0,1,…,15, output_ready = 1 → output_data = 15, output_valid one cycle after the 16th beat.
- All 16 elements = 5 → output_data = 0 (tie keeps lowest index).
- Element 7 = -1, all others = -100:
  - without ARGMAX_RELU_EN → 7
  - with ARGMAX_RELU_EN → 0
- Element 3 = 20'h7FFFF, all others = 20'h80000 → 3. This checks signed extremes.
- Backpressure case:
  - Vector A completes with output_ready = 0. Vector B elements 0..14 are accepted, then input_ready drops at element 15.
  - Raising output_ready takes A and accepts B's element 15 on the same edge. output_valid stays 1 and the next cycle shows B's index.
- Reset after 7 accepted elements, then 16 fresh elements with the max at index 9 → single result 9; no result from the partial vector.
- Randomised valid/ready on both sides over 833 vectors, compared against a reference model → zero mismatches.

Source files
------------

// File: rtl/argmax_stream_pkg.sv
// argmax_stream_pkg: shared data type, index-width helper and tie-break rule for argmax_stream
package argmax_stream_pkg;
  localparam int DATA_W = 20;
  typedef logic signed [DATA_W-1:0] data_t;
  localparam bit TIE_LOWEST = 1'b1;
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: optional ReLU clamp, strict signed compare and value/index select (ARGMAX_RELU_EN enables the clamp)
module argmax_cmp
  import argmax_stream_pkg::*;
#(
  parameter int T  = DATA_W,
  parameter int IW = 4
) (
  input  logic          first,
  input  logic [T-1:0]  data,
  input  logic [IW-1:0] idx,
  input  logic [T-1:0]  cur_val,
  input  logic [IW-1:0] cur_idx,
  output logic [T-1:0]  best_val,
  output logic [IW-1:0] best_idx
);
  logic [T-1:0] val;
  logic win;
`ifdef ARGMAX_RELU_EN
  assign val = data[T-1] ? '0 : data;
`else
  assign val = data;
`endif
  assign win = first || ($signed(val) > $signed(cur_val)) || (!TIE_LOWEST && val == cur_val);
  assign best_val = win ? val : cur_val;
  assign best_idx = win ? idx : cur_idx;
endmodule

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over M-element vectors with valid/ready on both sides (ARGMAX_RELU_EN clamps negatives to 0)
module argmax_stream
  import argmax_stream_pkg::*;
#(
  parameter int M = 16,
  parameter int T = DATA_W,
  localparam int IW = idx_w(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [T-1:0]  input_data,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [IW-1:0] output_data
);
  logic [IW-1:0] cnt;
  logic [T-1:0]  best_val;
  logic [IW-1:0] best_idx;
  logic [T-1:0]  nxt_val;
  logic [IW-1:0] nxt_idx;
  logic last, accept, take;
  assign last        = cnt == IW'(M - 1);
  assign input_ready = !(last && output_valid && !output_ready);
  assign accept      = input_valid && input_ready;
  assign take        = output_valid && output_ready;
  argmax_cmp #(.T(T), .IW(IW)) u_cmp (
    .first   (cnt == '0),
    .data    (input_data),
    .idx     (cnt),
    .cur_val (best_val),
    .cur_idx (best_idx),
    .best_val(nxt_val),
    .best_idx(nxt_idx)
  );
  // element counter and running best, advanced on every accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (accept) begin
      cnt      <= last ? '0 : cnt + IW'(1);
      best_val <= nxt_val;
      best_idx <= nxt_idx;
    end
  end
  // result register: a final beat loads it even when the old result leaves on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      output_valid <= 1'b0;
      output_data  <= '0;
    end else if (accept && last) begin
      output_valid <= 1'b1;
      output_data  <= nxt_idx;
    end else if (take) begin
      output_valid <= 1'b0;
    end
  end
endmodule
